// File: rtl/alu_multicycle.sv
// alu_multicycle: execution-stage ALU.
// AND/OR/ADD/SUB/SLT/NOR are combinational. MULT/DIV are signed, run 32
// iterations plus one fix-up cycle, and write the HI/LO registers.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   ALUInput  4-bit operation code from ALU control
//   A, B      32-bit operands (A: rs/dividend/multiplicand, B: rt/divisor/multiplier)
//   start     launches MULT/DIV when in idle
//   Result    combinational result, Zero = (Result == 0)
//   busy      high while MULT/DIV is in progress
//   done      one-cycle pulse when HI/LO have been written
//   HI, LO    product high/low word, or remainder/quotient
module alu_multicycle (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ALUInput,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpNor  = 4'b0011;
  localparam logic [3:0] OpMult = 4'b1010;
  localparam logic [3:0] OpDiv  = 4'b1111;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg_q;    // operand signs differ: negate product / quotient
  logic        r_neg_r;    // dividend negative: negate remainder
  logic        r_b_zero;
  logic [31:0] r_mcand;    // multiplicand magnitude (MULT) or divisor magnitude (DIV)
  logic [63:0] r_acc;      // MULT: {partial product, multiplier}; DIV: [31:0] dividend/quotient
  logic [31:0] r_rem;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Combinational ops
  always_comb begin
    Result = 32'd0;
    case (ALUInput)
      OpAnd:   Result = A & B;
      OpOr:    Result = A | B;
      OpAdd:   Result = A + B;
      OpSub:   Result = A - B;
      OpSlt:   Result = {31'd0, ($signed(A) < $signed(B))};
      OpNor:   Result = ~(A | B);
      default: Result = 32'd0;
    endcase
  end

  assign Zero = (Result == 32'd0);

  logic w_launch;
  assign w_launch = (r_state == StIdle) && start && ((ALUInput == OpMult) || (ALUInput == OpDiv));

  // 0x80000000 maps to 2^31, which still fits an unsigned 32-bit magnitude.
  logic [31:0] w_mag_a, w_mag_b;
  assign w_mag_a = A[31] ? (~A + 32'd1) : A;
  assign w_mag_b = B[31] ? (~B + 32'd1) : B;

  // Shift-add step: conditionally add multiplicand to upper half, shift right.
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_nxt;
  assign w_mul_sum = {1'b0, r_acc[63:32]} + {1'b0, r_mcand};
  assign w_mul_nxt = r_acc[0] ? {w_mul_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};

  // Restoring-division step on a 33-bit partial remainder.
  logic [32:0] w_rem_sh, w_rem_sub;
  logic        w_rem_ge;
  logic [31:0] w_rem_nxt, w_quo_nxt;
  assign w_rem_sh  = {r_rem, r_acc[31]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_mcand};
  assign w_rem_ge  = ~w_rem_sub[32];
  assign w_rem_nxt = w_rem_ge ? w_rem_sub[31:0] : w_rem_sh[31:0];
  assign w_quo_nxt = {r_acc[30:0], w_rem_ge};

  // Sign fix-up
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem;
  assign w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
  assign w_quo  = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem  = r_neg_r ? (~r_rem + 32'd1) : r_rem;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_launch) w_state_nxt = StRun;
      StRun:   if (r_cnt == 5'd31) w_state_nxt = StFix;
      StFix:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_cnt    <= 5'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_mcand  <= 32'd0;
      r_acc    <= 64'd0;
      r_rem    <= 32'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_launch) begin
            r_is_div <= (ALUInput == OpDiv);
            r_neg_q  <= A[31] ^ B[31];
            r_neg_r  <= A[31];
            r_b_zero <= (B == 32'd0);
            r_mcand  <= (ALUInput == OpDiv) ? w_mag_b : w_mag_a;
            r_acc    <= {32'd0, (ALUInput == OpDiv) ? w_mag_a : w_mag_b};
            r_rem    <= 32'd0;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b1;
          end
        end
        StRun: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_is_div) begin
            r_acc[31:0] <= w_quo_nxt;
            r_rem       <= w_rem_nxt;
          end else begin
            r_acc <= w_mul_nxt;
          end
        end
        StFix: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_is_div) begin
            // Divide by zero: remainder path already reconstructs A; force quotient to all ones.
            r_lo <= r_b_zero ? 32'hFFFF_FFFF : w_quo;
            r_hi <= w_rem;
          end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ALUInput;
  logic [31:0] A, B;
  logic        start;
  logic [31:0] Result;
  logic        Zero;
  logic        busy;
  logic        done;
  logic [31:0] HI, LO;

  localparam logic [3:0] CMult = 4'b1010;
  localparam logic [3:0] CDiv  = 4'b1111;

  alu_multicycle dut (
    .clk      (clk),
    .reset    (reset),
    .ALUInput (ALUInput),
    .A        (A),
    .B        (B),
    .start    (start),
    .Result   (Result),
    .Zero     (Zero),
    .busy     (busy),
    .done     (done),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] comb_ref(input logic [3:0] code, input logic [31:0] a,
                                           input logic [31:0] b);
    case (code)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic mdu_ref(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (code == CMult) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endtask

  function automatic logic [3:0] rnd_code();
    logic [3:0] codes [9];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0011, CMult, CDiv, 4'b0101};
    return codes[$urandom_range(0, 8)];
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: begin
        v = $urandom_range(0, 20);
        return $urandom_range(0, 1) ? (~v + 32'd1) : v;
      end
      default: return $urandom;
    endcase
  endfunction

  task automatic check_comb(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    ALUInput = code;
    A = a;
    B = b;
    #1;
    r = comb_ref(code, a, b);
    check("result", Result, r);
    check("zero", {31'd0, Zero}, {31'd0, (r == 32'd0)});
  endtask

  task automatic check_regs(input string tag, input logic b, input logic d);
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
  endtask

  // Launch at E0, check every edge through E33; chain leaves start for E34 to the next call.
  task automatic do_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                       input int restart_at, input bit chain);
    logic [31:0] hi, lo;
    mdu_ref(code, a, b, hi, lo);
    ALUInput = code;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_regs("launch", 1'b1, 1'b0);
    for (int e = 1; e <= 32; e++) begin
      if (e == restart_at) begin
        ALUInput = (code == CMult) ? CDiv : CMult;
        A = $urandom;
        B = $urandom;
        start = 1'b1;
      end else begin
        check_comb(rnd_code(), rnd_operand(), rnd_operand());
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      check_regs("run", 1'b1, 1'b0);
    end
    check_comb(rnd_code(), rnd_operand(), rnd_operand());
    @(posedge clk);
    #1;
    exp_hi = hi;
    exp_lo = lo;
    check_regs("fix", 1'b0, 1'b1);
    if (!chain) begin
      @(posedge clk);
      #1;
      check_regs("after", 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ALUInput = 4'b0000;
    A = 32'd0;
    B = 32'd0;
    #13;
    check_regs("reset", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Directed combinational ops
    check_comb(4'b0010, 32'd5, 32'd7);
    check_comb(4'b0110, 32'd3, 32'd3);
    check_comb(4'b0111, 32'hFFFF_FFFF, 32'd1);
    check_comb(4'b0011, 32'd0, 32'd0);
    check_comb(CMult, 32'd9, 32'd9);
    check("add_val", comb_ref(4'b0010, 32'd5, 32'd7), 32'd12);

    // start with a non-MULT/DIV code must be ignored
    ALUInput = 4'b0010;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_regs("ign_start", 1'b0, 1'b0);

    // Directed MULT/DIV with restart attempt, back-to-back launches
    do_op(CMult, 32'hFFFF_FFFD, 32'd7, 10, 1'b1);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFEB);
    do_op(CDiv, 32'hFFFF_FFF9, 32'd2, 0, 1'b1);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    do_op(CDiv, 32'h0000_1234, 32'd0, 5, 1'b0);
    check("div0_lo", LO, 32'hFFFF_FFFF);
    check("div0_hi", HI, 32'h0000_1234);
    do_op(CMult, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    check("mmin_hi", HI, 32'h4000_0000);
    do_op(CDiv, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    check("dmin_lo", LO, 32'h8000_0000);
    do_op(CMult, 32'd123456, 32'hFFFF_FF00, 0, 1'b0);

    // Reset mid-op
    ALUInput = CMult;
    A = 32'hDEAD_BEEF;
    B = 32'h1234_5678;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check_regs("midrst", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_regs("post_rst", 1'b0, 1'b0);
    do_op(CDiv, 32'd1000, 32'hFFFF_FFF9, 0, 1'b0);

    // Randomized MULT/DIV
    for (int i = 0; i < 40; i++) begin
      do_op($urandom_range(0, 1) ? CMult : CDiv, rnd_operand(), rnd_operand(),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32)) : 0,
            1'($urandom_range(0, 1)));
    end
    @(posedge clk);
    #1;

    // Randomized combinational ops while idle
    for (int i = 0; i < 60; i++) begin
      check_comb(rnd_code(), rnd_operand(), rnd_operand());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
